bar_run_scan: RTL

BAR_RUN_SCAN -- requirements
Module: bar_run_scan

---
 rtl/bar_run_scan_pkg.sv | 21 ++
 rtl/bar_run_scan_quant.sv | 69 ++++++
 rtl/bar_run_scan.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/bar_run_scan_pkg.sv
// bar_scan_pkg: shared types and constants for the barcode run scanner.
//   state_t     - scanner FSM states
//   elem_t      - element width in modules minus 1 (0..3 => 1..4 modules)
//   EAN_MODULES - modules in a full EAN-13 symbol
//   EAN_ELEMS   - bars + spaces in a full EAN-13 symbol
package bar_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEEK,
    ST_LINE,
    ST_CHECK,
    ST_OUT
  } state_t;

  typedef logic [1:0] elem_t;

  localparam int unsigned EAN_MODULES = 95;
  localparam int unsigned EAN_ELEMS   = 59;

endpackage

// File: rtl/bar_run_scan_quant.sv
// run_quant: converts one run length into a module count relative to the
// unit width u. Registered, one cycle latency.
//   clk, rst   - clock, synchronous active-high reset
//   in_valid   - a run closed this cycle
//   run_len    - run length in pixels
//   unit       - unit (single module) width in pixels
//   run_sat    - run counter saturated; always an error
//   out_valid  - registered result valid
//   out_width  - modules minus 1
//   out_err    - run too wide (2r >= 9u) or saturated
module run_quant
  import bar_scan_pkg::*;
#(
  parameter int unsigned X_W = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [X_W-1:0] run_len,
  input  logic [X_W-1:0] unit,
  input  logic           run_sat,
  output logic           out_valid,
  output elem_t          out_width,
  output logic           out_err
);

  // 9u needs X_W+4 bits; every threshold is formed at that width so none truncates.
  localparam int unsigned CW = X_W + 4;

  logic [CW-1:0] uu, r2, u3, u5, u7, u9;

  always_comb begin
    uu = CW'(unit);
    r2 = CW'(run_len) << 1;
    u3 = (uu << 1) + uu;
    u5 = (uu << 2) + uu;
    u7 = (uu << 3) - uu;
    u9 = (uu << 3) + uu;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_width <= '0;
      out_err   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_err <= 1'b0;
        if (run_sat) begin
          out_width <= 2'd3;
          out_err   <= 1'b1;
        end else if (r2 < u3) begin
          out_width <= 2'd0;
        end else if (r2 < u5) begin
          out_width <= 2'd1;
        end else if (r2 < u7) begin
          out_width <= 2'd2;
        end else if (r2 < u9) begin
          out_width <= 2'd3;
        end else begin
          out_width <= 2'd3;
          out_err   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bar_run_scan.sv
// bar_run_scan: scans up to SCAN_LINES rows of a binarised frame for a
// 1-D barcode, converts bar/space runs to module widths and, once one row
// yields exactly ELEM_CNT clean elements, streams them out with valid/ready.
//   clk, rst          - clock, synchronous active-high reset
//   frame_start       - one-cycle frame start pulse
//   pix_de/x/y/data   - pixel stream (pix_data == BAR_POL means bar)
//   elem_valid/ready  - element handshake
//   elem_width        - element width in modules minus 1
//   elem_last         - final element of the stream
//   scan_ok/scan_fail - one-cycle row accepted / all rows rejected pulses
//   busy              - FSM not idle
module bar_run_scan
  import bar_scan_pkg::*;
#(
  parameter int unsigned X_W        = 10,
  parameter int unsigned Y_W        = 10,
  parameter int unsigned SCAN_Y0    = 100,
  parameter int unsigned SCAN_STEP  = 20,
  parameter int unsigned SCAN_LINES = 8,
  parameter int unsigned ELEM_CNT   = EAN_ELEMS,
  parameter int unsigned DEPTH      = 64,
  parameter bit          BAR_POL    = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           frame_start,
  input  logic           pix_de,
  input  logic [X_W-1:0] pix_x,
  input  logic [Y_W-1:0] pix_y,
  input  logic           pix_data,
  output logic           elem_valid,
  input  logic           elem_ready,
  output logic [1:0]     elem_width,
  output logic           elem_last,
  output logic           scan_ok,
  output logic           scan_fail,
  output logic           busy
);

  localparam int unsigned K_W   = $clog2(SCAN_LINES + 1);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_t           state;
  logic [K_W-1:0]   k;
  logic [CNT_W-1:0] count;
  logic [X_W-1:0]   u, run_cnt;
  logic             u_set, started, cur_bar, line_err, ovf, flushing;
  logic [IDX_W-1:0] rd_idx;
  elem_t            buffer [DEPTH];

  logic [31:0]      row_target;
  logic             y_match, is_bar, line_live, run_close;
  logic [X_W-1:0]   q_unit;
  logic             q_sat, q_valid, q_err, wr_en;
  elem_t            q_width;

  // Run lengths come from pix_de counts; the column number is not needed.
  logic pix_x_unused;
  assign pix_x_unused = ^pix_x;

  assign row_target = SCAN_Y0 + (32'(k) * SCAN_STEP);
  assign y_match    = (32'(pix_y) == row_target);
  assign is_bar     = (pix_data == BAR_POL);
  assign busy       = (state != ST_IDLE);

  // A run closes on a level change, or when pix_de drops while inside a bar;
  // a background run still open at the drop is trailing and is discarded.
  always_comb begin
    line_live = (state == ST_LINE) && !flushing;
    run_close = line_live && started &&
                ((pix_de && (is_bar != cur_bar)) || (!pix_de && cur_bar));
    q_unit    = u_set ? u : run_cnt;  // first bar run sets u as it closes
    q_sat     = &run_cnt;
    wr_en     = q_valid && !q_err && (count < CNT_W'(DEPTH));
  end

  run_quant #(.X_W(X_W)) u_quant (
    .clk      (clk),
    .rst      (rst),
    .in_valid (run_close),
    .run_len  (run_cnt),
    .unit     (q_unit),
    .run_sat  (q_sat),
    .out_valid(q_valid),
    .out_width(q_width),
    .out_err  (q_err)
  );

  always_ff @(posedge clk) begin
    if (wr_en) buffer[count[IDX_W-1:0]] <= q_width;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      k          <= '0;
      count      <= '0;
      u          <= '0;
      run_cnt    <= '0;
      u_set      <= 1'b0;
      started    <= 1'b0;
      cur_bar    <= 1'b0;
      line_err   <= 1'b0;
      ovf        <= 1'b0;
      flushing   <= 1'b0;
      rd_idx     <= '0;
      elem_valid <= 1'b0;
      elem_width <= '0;
      elem_last  <= 1'b0;
      scan_ok    <= 1'b0;
      scan_fail  <= 1'b0;
    end else begin
      scan_ok   <= 1'b0;
      scan_fail <= 1'b0;

      // Quantiser results land one cycle after their run closed. A result
      // left over from an aborted line is overridden by the clear on LINE entry.
      if (q_valid) begin
        if (q_err) line_err <= 1'b1;
        else if (count == CNT_W'(DEPTH)) ovf <= 1'b1;
        else count <= count + CNT_W'(1);
      end

      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            state <= ST_SEEK;
            k     <= '0;
          end
        end

        ST_SEEK: begin
          if (frame_start) begin
            k <= '0;
          end else if (pix_de && y_match) begin
            // The pixel that matches the row is also its first pixel.
            state    <= ST_LINE;
            started  <= is_bar;
            cur_bar  <= 1'b1;
            run_cnt  <= X_W'(1);
            u        <= '0;
            u_set    <= 1'b0;
            count    <= '0;
            line_err <= 1'b0;
            ovf      <= 1'b0;
            flushing <= 1'b0;
          end
        end

        ST_LINE: begin
          if (frame_start) begin
            state <= ST_SEEK;
            k     <= '0;
          end else if (flushing) begin
            state <= ST_CHECK;
          end else if (!pix_de) begin
            flushing <= 1'b1;
            if (started && cur_bar && !u_set) begin
              u     <= run_cnt;
              u_set <= 1'b1;
            end
          end else if (!started) begin
            if (is_bar) begin
              started <= 1'b1;
              cur_bar <= 1'b1;
              run_cnt <= X_W'(1);
            end
          end else if (is_bar == cur_bar) begin
            if (!q_sat) run_cnt <= run_cnt + X_W'(1);
          end else begin
            cur_bar <= is_bar;
            run_cnt <= X_W'(1);
            if (cur_bar && !u_set) begin
              u     <= run_cnt;
              u_set <= 1'b1;
            end
          end
        end

        ST_CHECK: begin
          if (frame_start) begin
            state <= ST_SEEK;
            k     <= '0;
          end else if (count == CNT_W'(ELEM_CNT) && !line_err && !ovf) begin
            state   <= ST_OUT;
            scan_ok <= 1'b1;
            rd_idx  <= '0;
          end else if (k == K_W'(SCAN_LINES - 1)) begin
            state     <= ST_IDLE;
            scan_fail <= 1'b1;
          end else begin
            k     <= k + K_W'(1);
            state <= ST_SEEK;
          end
        end

        ST_OUT: begin
          if (!elem_valid) begin
            elem_valid <= 1'b1;
            elem_width <= buffer[rd_idx];
            elem_last  <= (rd_idx == IDX_W'(ELEM_CNT - 1));
          end else if (elem_ready) begin
            if (elem_last) begin
              elem_valid <= 1'b0;
              elem_last  <= 1'b0;
              state      <= ST_IDLE;
            end else begin
              rd_idx     <= rd_idx + IDX_W'(1);
              elem_width <= buffer[rd_idx + IDX_W'(1)];
              elem_last  <= ((rd_idx + IDX_W'(1)) == IDX_W'(ELEM_CNT - 1));
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
